// File: rtl/gaussian_pkg.sv
// Shared types, geometry defaults and 3x3 Gaussian kernel helpers for the
// gaussian_pixel_loader front end of the Canny pipeline.
package gaussian_pkg;

  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;
  localparam int SUM_W          = 12;

  typedef logic [7:0] pixel_t;

  // Row-major 3x3 window: w[2] is the top row, and w[r][2] is the left (oldest) column.
  // Bits [71:64] hold the top-left pixel and bits [7:0] hold the bottom-right pixel.
  typedef pixel_t [2:0][2:0] window_t;

  localparam logic [SUM_W-1:0] K_CORNER = SUM_W'(1);
  localparam logic [SUM_W-1:0] K_EDGE   = SUM_W'(2);
  localparam logic [SUM_W-1:0] K_CENTRE = SUM_W'(4);

  function automatic logic [SUM_W-1:0] gauss_sum(input window_t w);
    logic [SUM_W-1:0] corners;
    logic [SUM_W-1:0] edges;
    corners = SUM_W'(w[2][2]) + SUM_W'(w[2][0]) + SUM_W'(w[0][2]) + SUM_W'(w[0][0]);
    edges   = SUM_W'(w[2][1]) + SUM_W'(w[1][2]) + SUM_W'(w[1][0]) + SUM_W'(w[0][1]);
    return corners * K_CORNER + edges * K_EDGE + SUM_W'(w[1][1]) * K_CENTRE;
  endfunction

endpackage

// File: rtl/line_window_buffer.sv
// Raster counters, two line buffers and the 3x3 sliding window register.
// pixel_data_out_valid marks a complete window whose pixels all lie inside the image.
module line_window_buffer
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic    clk,
  input  logic    rstN,
  input  pixel_t  pixel_in,
  input  logic    pixel_in_valid,
  output window_t pixel_data_out,
  output logic    pixel_data_out_valid
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pixel_t        line1 [IMG_WIDTH];
  pixel_t        line2 [IMG_WIDTH];
  pixel_t        row1_rd;
  pixel_t        row2_rd;
  window_t       win;

  assign row1_rd        = line1[col];
  assign row2_rd        = line2[col];
  assign pixel_data_out = win;

  // line1 holds row r-1 and line2 holds row r-2. Each accepted pixel moves one column down by one row.
  // These RAMs are never reset. Rows 0 and 1 are rewritten before any window uses them.
  always_ff @(posedge clk) begin
    if (pixel_in_valid) begin
      line2[col] <= row1_rd;
      line1[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      col                  <= '0;
      row                  <= '0;
      win                  <= '0;
      pixel_data_out_valid <= 1'b0;
    end else begin
      pixel_data_out_valid <= pixel_in_valid && (col >= COL_TWO) && (row >= ROW_TWO);
      if (pixel_in_valid) begin
        win[2] <= {win[2][1:0], row2_rd};
        win[1] <= {win[1][1:0], row1_rd};
        win[0] <= {win[0][1:0], pixel_in};
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gaussian_pixel_loader.sv
// 3x3 Gaussian smoothing stage. It uses the window buffer plus one register for the convolution result.
// Define GAUSSIAN_ROUND_EN to round half up when normalising. Otherwise the sum is truncated.
module gaussian_pixel_loader
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic [71:0] pixel_data_out,
  output logic        pixel_data_out_valid,
  output logic [7:0]  gaussian_pixel_out,
  output logic        gaussian_pixel_out_valid
);

  window_t          win;
  logic             win_valid;
  logic [SUM_W-1:0] sum;
  pixel_t           norm;

  line_window_buffer #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_line_window_buffer (
    .clk                  (clk),
    .rstN                 (rstN),
    .pixel_in             (pixel_in),
    .pixel_in_valid       (pixel_in_valid),
    .pixel_data_out       (win),
    .pixel_data_out_valid (win_valid)
  );

  assign pixel_data_out       = win;
  assign pixel_data_out_valid = win_valid;
  assign sum                  = gauss_sum(win);

`ifdef GAUSSIAN_ROUND_EN
  // The maximum is (4080 + 8) >> 4 = 255, so the 12-bit sum cannot overflow.
  assign norm = pixel_t'((sum + SUM_W'(8)) >> 4);
`else
  assign norm = pixel_t'(sum >> 4);
`endif

  // Each valid is a one-cycle pulse. The data holds its last value while the valid is low.
  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      gaussian_pixel_out       <= '0;
      gaussian_pixel_out_valid <= 1'b0;
    end else begin
      gaussian_pixel_out_valid <= win_valid;
      if (win_valid) gaussian_pixel_out <= norm;
    end
  end

endmodule

// File: tb/tb_gaussian_pixel_loader.sv
// Scoreboard bench for gaussian_pixel_loader on an 8x6 image.
// A frame-array model predicts each window, each filtered value and the cycle on which each is due.
module tb_gaussian_pixel_loader;
  import gaussian_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic [71:0] pixel_data_out;
  logic        pixel_data_out_valid;
  logic [7:0]  gaussian_pixel_out;
  logic        gaussian_pixel_out_valid;

  gaussian_pixel_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                      (clk),
    .rstN                     (rstN),
    .pixel_in                 (pixel_in),
    .pixel_in_valid           (pixel_in_valid),
    .pixel_data_out           (pixel_data_out),
    .pixel_data_out_valid     (pixel_data_out_valid),
    .gaussian_pixel_out       (gaussian_pixel_out),
    .gaussian_pixel_out_valid (gaussian_pixel_out_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int g_cnt    = 0;
  int w_cnt    = 0;

  logic [7:0]  exp_q[$];
  logic [71:0] exp_win_q[$];
  int          gcyc_q[$];
  int          wcyc_q[$];

  logic [7:0] img [H][W];
  int m_r = 0;
  int m_c = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r][c]);
  endfunction

  function automatic logic [7:0] model_gauss(input int r, input int c);
    int s;
    s = px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c)
      + 2*px(r-1,c-2) + 4*px(r-1,c-1) + 2*px(r-1,c)
      + px(r,c-2) + 2*px(r,c-1) + px(r,c);
`ifdef GAUSSIAN_ROUND_EN
    s = s + 8;
`endif
    return 8'(s >> 4);
  endfunction

  function automatic logic [71:0] model_win(input int r, input int c);
    return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
            img[r-1][c-2], img[r-1][c-1], img[r-1][c],
            img[r][c-2],   img[r][c-1],   img[r][c]};
  endfunction

  // driver tasks
  task automatic drive(input logic [7:0] v, input bit vld);
    @(negedge clk);
    pixel_in       = v;
    pixel_in_valid = vld;
    if (vld) begin
      img[m_r][m_c] = v;
      if (m_r >= 2 && m_c >= 2) begin
        exp_win_q.push_back(model_win(m_r, m_c));
        wcyc_q.push_back(cyc + 1);
        exp_q.push_back(model_gauss(m_r, m_c));
        gcyc_q.push_back(cyc + 2);
      end
      if (m_c == W-1) begin
        m_c = 0;
        m_r = (m_r == H-1) ? 0 : m_r + 1;
      end else begin
        m_c = m_c + 1;
      end
    end
  endtask

  // mode: 0 constant 100, 1 impulse at (2,2), 2 index mod 256, 3 random
  task automatic stream(input int mode, input bit gapped, input int n_pix);
    logic [7:0] v;
    for (int i = 0; i < n_pix; i++) begin
      case (mode)
        0:       v = 8'd100;
        1:       v = ((i / W) % H == 2 && i % W == 2) ? 8'd255 : 8'd0;
        2:       v = 8'(i % (W*H));
        default: v = 8'($urandom_range(0, 255));
      endcase
      drive(v, 1'b1);
      if (gapped) drive(8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic begin_phase();
    g_cnt = 0;
    w_cnt = 0;
  endtask

  task automatic end_phase(input string tag, input int exp_cnt);
    for (int i = 0; i < 4; i++) drive(8'd0, 1'b0);
    check({tag, "_gauss_count"}, 72'(g_cnt), 72'(exp_cnt));
    check({tag, "_win_count"}, 72'(w_cnt), 72'(exp_cnt));
    check({tag, "_queue_empty"}, 72'(exp_q.size()), 72'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win"}, pixel_data_out, 72'(0));
    check({tag, "_win_valid"}, 72'(pixel_data_out_valid), 72'(0));
    check({tag, "_gauss"}, 72'(gaussian_pixel_out), 72'(0));
    check({tag, "_gauss_valid"}, 72'(gaussian_pixel_out_valid), 72'(0));
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rstN) begin
      if (pixel_data_out_valid) begin
        w_cnt++;
        if (exp_win_q.size() == 0) begin
          check("win_spurious", 72'(1), 72'(0));
        end else begin
          check("window", pixel_data_out, exp_win_q.pop_front());
          check("win_cycle", 72'(cyc), 72'(wcyc_q.pop_front()));
        end
      end
      if (gaussian_pixel_out_valid) begin
        g_cnt++;
        if (exp_q.size() == 0) begin
          check("gauss_spurious", 72'(1), 72'(0));
        end else begin
          check("gauss", 72'(gaussian_pixel_out), 72'(exp_q.pop_front()));
          check("gauss_cycle", 72'(cyc), 72'(gcyc_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rstN           = 1'b1;
    pixel_in       = 8'd0;
    pixel_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstN = 1'b0;

    begin_phase(); stream(0, 1'b0, W*H); end_phase("const100", 24);
    begin_phase(); stream(1, 1'b0, W*H); end_phase("impulse", 24);
    begin_phase(); stream(2, 1'b0, W*H); end_phase("index", 24);
    begin_phase(); stream(3, 1'b1, W*H); end_phase("gapped", 24);

    // Reset after 30 pixels, with windows and filtered outputs already produced.
    begin_phase();
    stream(3, 1'b0, 30);
    @(negedge clk);
    pixel_in_valid = 1'b0;
    #2 rstN = 1'b1;
    exp_q.delete(); exp_win_q.delete(); gcyc_q.delete(); wcyc_q.delete();
    m_r = 0;
    m_c = 0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    begin_phase(); stream(3, 1'b0, W*H); end_phase("after_reset", 24);

    begin_phase(); stream(3, 1'b0, 2*W*H); end_phase("two_frames", 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
